inst_rom_arbiter: RTL and testbench
===================================

Name: inst_rom_arbiter

Overview:
Shares the single combinational instruction ROM read port between two requesters: port 0 is the IF-stage fetch and port 1 is a secondary reader (debug/loader or load-from-text-segment path). The block arbitrates each cycle, drives ROM chip-enable and address, and registers the returned word into a per-port response with a one-cycle valid pulse. Port 1 is protected from starvation by a bounded-priority counter. The block sits between pc_reg/IF and the instruction ROM, and raises a stall request to the pipeline controller when a fetch is denied.

Parameters:
ADDR_W, 32, requester/ROM byte-address width
DATA_W, 32, instruction word width
STARVE_MAX, 4, maximum consecutive port-0 grants while port 1 waits (range 1..15)

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous reset, active low
m0_req  in  1  fetch request, level
m0_addr  in  ADDR_W  fetch byte address
m0_gnt  out  1  combinational grant to port 0
m0_rvalid  out  1  port-0 read data valid, one-cycle pulse
m0_rdata  out  DATA_W  port-0 read data, registered
m1_req  in  1  secondary request, level
m1_addr  in  ADDR_W  secondary byte address
m1_gnt  out  1  combinational grant to port 1
m1_rvalid  out  1  port-1 read data valid pulse
m1_rdata  out  DATA_W  port-1 read data, registered
rom_ce  out  1  ROM chip enable (1 = enable, 0 = ChipDisable)
rom_addr  out  ADDR_W  ROM byte address
rom_data  in  DATA_W  ROM combinational read data
stall_req  out  1  to pipeline ctrl: m0_req && !m0_gnt

Behaviour:
- One clock domain; rst_n asynchronous, active low, released synchronously by the top level.
- Reset values: m0_rvalid = m1_rvalid = 0; m0_rdata = m1_rdata = 0; starvation counter = 0; last_owner = NONE.
- Arbitration is combinational within the request cycle, and at most one grant is asserted per cycle:
  - Only m0_req: grant port 0.
  - Only m1_req: grant port 1.
  - Both requesting: grant port 1 if starve_cnt == STARVE_MAX, otherwise grant port 0.
  - Neither requesting: no grant.
- starve_cnt (4-bit), updated on each rising clk edge:
  - Increments when port 0 is granted while m1_req = 1.
  - Clears to 0 on a port-1 grant, or on any cycle with m1_req = 0.
  - Saturates at STARVE_MAX and never wraps.
- ROM drive:
  - rom_ce = m0_gnt | m1_gnt.
  - rom_addr = address of the granted port, else 0.
  - With rom_ce = 0, rom_data is don't-care and is not sampled.
- Latency is exactly 1 cycle. On the clock edge that closes a granted cycle, rom_data is captured into mX_rdata, and mX_rvalid = 1 for the following cycle only.
- mX_rdata holds its value until the next mX_rvalid; the other port's rdata is never disturbed.
- FSM last_owner {NONE, P0, P1} records the port whose data is presented this cycle:
  - NONE→P0 on a port-0 grant, NONE→P1 on a port-1 grant, any→NONE on no grant.
  - mX_rvalid is decoded from last_owner.
- Back-to-back: continuous m0_req with m1_req = 0 gives a grant every cycle and an rvalid every cycle (full throughput).
- A request held while not granted keeps its address stable (requester obligation). Dropping the request without a grant is legal and has no side effect.
- Address alignment: the ROM index uses addr[ADDR_W-1:2]; bits [1:0] are passed through unchanged to rom_addr.
- Async reset mid-operation: a pending rvalid is dropped immediately, rdata is zeroed, the counter is cleared, and no stale pulse appears after reset release.
- stall_req is purely combinational, with no registered delay.

Optional Feature:
Macro ARB_ALIGN_CHECK_EN.
- When defined:
  - Adds outputs m0_err and m1_err (1 bit each, reset 0), aligned with rvalid.
  - A granted request with addr[1:0] != 0 still counts as a grant for arbitration and the counter.
  - It drives rom_ce = 0, and on the next cycle gives mX_rvalid = 1, mX_err = 1, mX_rdata = 0.
- When undefined: no err ports exist, and a misaligned address is forwarded to the ROM unchanged.

Test Plan:
- Reset then idle: rst_n low for 3 cycles, no requests -> all outputs 0, rom_ce = 0.
- Single fetch: m0_req = 1, m0_addr = 0x0000_0008, ROM word[2] = 0x3401_1100 -> m0_gnt same cycle, rom_addr = 0x8, next cycle m0_rvalid = 1 and m0_rdata = 0x3401_1100; stall_req = 0.
- Streaming: m0 addresses 0x0, 0x4, 0x8, 0xC on 4 consecutive cycles -> 4 consecutive rvalid pulses with words[0..3] in order.
- Contention / starvation with STARVE_MAX = 4: both requesting continuously -> port 0 is granted 4 cycles, then port 1 is granted on cycle 5 with stall_req = 1 in that cycle, then port 0 resumes. The pattern repeats 4:1, and m1_rdata is unchanged while port 0 is served.
- Reset mid-read: grant port 1 at 0x10, assert rst_n low half a cycle after the edge -> m1_rvalid drops to 0 immediately and no rvalid appears after release.
- ARB_ALIGN_CHECK_EN: m0_addr = 0x0000_0006 -> rom_ce = 0, next cycle m0_rvalid = 1, m0_err = 1, m0_rdata = 0.

Source files
------------

// File: rtl/inst_rom_arbiter.sv
// Two-port arbiter for the instruction ROM read port: IF fetch (port 0) vs secondary reader (port 1).
// Optional ARB_ALIGN_CHECK_EN adds misaligned-address error responses on m0_err/m1_err.
module inst_rom_arbiter #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              m0_req,
  input  logic [ADDR_W-1:0] m0_addr,
  output logic              m0_gnt,
  output logic              m0_rvalid,
  output logic [DATA_W-1:0] m0_rdata,
  input  logic              m1_req,
  input  logic [ADDR_W-1:0] m1_addr,
  output logic              m1_gnt,
  output logic              m1_rvalid,
  output logic [DATA_W-1:0] m1_rdata,
  output logic              rom_ce,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [DATA_W-1:0] rom_data,
`ifdef ARB_ALIGN_CHECK_EN
  output logic              m0_err,
  output logic              m1_err,
`endif
  output logic              stall_req
);

  typedef enum logic [1:0] {
    NONE = 2'd0,
    P0   = 2'd1,
    P1   = 2'd2
  } owner_t;

  localparam logic [3:0] SMAX = 4'(STARVE_MAX);

  owner_t     last_owner;
  logic [3:0] starve_cnt;
  logic       mis0;
  logic       mis1;

`ifdef ARB_ALIGN_CHECK_EN
  assign mis0 = |m0_addr[1:0];
  assign mis1 = |m1_addr[1:0];
`else
  assign mis0 = 1'b0;
  assign mis1 = 1'b0;
`endif

  // Port 1 wins a contended cycle only once port 0 has used its quota.
  always_comb begin
    m0_gnt = 1'b0;
    m1_gnt = 1'b0;
    unique case (1'b1)
      (m0_req && m1_req): begin
        if (starve_cnt == SMAX) m1_gnt = 1'b1;
        else                    m0_gnt = 1'b1;
      end
      (m0_req && !m1_req): m0_gnt = 1'b1;
      (!m0_req && m1_req): m1_gnt = 1'b1;
      default: ;
    endcase
  end

  always_comb begin
    rom_addr = '0;
    if (m0_gnt)      rom_addr = m0_addr;
    else if (m1_gnt) rom_addr = m1_addr;
  end

  assign rom_ce    = (m0_gnt & ~mis0) | (m1_gnt & ~mis1);
  assign stall_req = m0_req & ~m0_gnt;

  assign m0_rvalid = (last_owner == P0);
  assign m1_rvalid = (last_owner == P1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_owner <= NONE;
    end else if (m0_gnt) begin
      last_owner <= P0;
    end else if (m1_gnt) begin
      last_owner <= P1;
    end else begin
      last_owner <= NONE;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      starve_cnt <= '0;
    end else if (!m1_req || m1_gnt) begin
      starve_cnt <= '0;
    end else if (m0_gnt && starve_cnt != SMAX) begin
      starve_cnt <= starve_cnt + 4'd1;
    end
  end

  // Misaligned grants never enable the ROM, so return zero instead of rom_data.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m0_rdata <= '0;
      m1_rdata <= '0;
    end else begin
      if (m0_gnt) m0_rdata <= mis0 ? '0 : rom_data;
      if (m1_gnt) m1_rdata <= mis1 ? '0 : rom_data;
    end
  end

`ifdef ARB_ALIGN_CHECK_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m0_err <= 1'b0;
      m1_err <= 1'b0;
    end else begin
      m0_err <= m0_gnt & mis0;
      m1_err <= m1_gnt & mis1;
    end
  end
`endif

endmodule

// File: tb/tb_inst_rom_arbiter.sv
// Directed bench for inst_rom_arbiter with a behavioural ROM.
// Table vectors cover single-cycle behaviour; hand sequences cover starvation and reset.
module tb_inst_rom_arbiter;

  localparam int AW = 32;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          m0_req = 1'b0;
  logic [AW-1:0] m0_addr = '0;
  logic          m0_gnt;
  logic          m0_rvalid;
  logic [DW-1:0] m0_rdata;
  logic          m1_req = 1'b0;
  logic [AW-1:0] m1_addr = '0;
  logic          m1_gnt;
  logic          m1_rvalid;
  logic [DW-1:0] m1_rdata;
  logic          rom_ce;
  logic [AW-1:0] rom_addr;
  logic [DW-1:0] rom_data;
  logic          stall_req;
`ifdef ARB_ALIGN_CHECK_EN
  logic          m0_err;
  logic          m1_err;
`endif

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  inst_rom_arbiter #(.ADDR_W(AW), .DATA_W(DW), .STARVE_MAX(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .m0_req(m0_req), .m0_addr(m0_addr), .m0_gnt(m0_gnt),
    .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata),
    .m1_req(m1_req), .m1_addr(m1_addr), .m1_gnt(m1_gnt),
    .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata),
    .rom_ce(rom_ce), .rom_addr(rom_addr), .rom_data(rom_data),
`ifdef ARB_ALIGN_CHECK_EN
    .m0_err(m0_err), .m1_err(m1_err),
`endif
    .stall_req(stall_req)
  );

  function automatic logic [DW-1:0] word(input logic [AW-3:0] i);
    if (i == 30'd2) return 32'h3401_1100;
    return 32'hA000_0000 | 32'(i);
  endfunction

  assign rom_data = rom_ce ? word(rom_addr[AW-1:2]) : 32'hDEAD_BEEF;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  typedef struct {
    logic          r0;
    logic [AW-1:0] a0;
    logic          r1;
    logic [AW-1:0] a1;
    logic          g0, g1, st, ce;
    logic [AW-1:0] ra;
    logic          v0, v1;
    logic [DW-1:0] d0, d1;
  } vec_t;

  function automatic vec_t mk(
    input logic r0, input logic [AW-1:0] a0,
    input logic r1, input logic [AW-1:0] a1,
    input logic g0, input logic g1, input logic st, input logic ce,
    input logic [AW-1:0] ra, input logic v0, input logic v1,
    input logic [DW-1:0] d0, input logic [DW-1:0] d1);
    vec_t v;
    v.r0 = r0; v.a0 = a0; v.r1 = r1; v.a1 = a1;
    v.g0 = g0; v.g1 = g1; v.st = st; v.ce = ce; v.ra = ra;
    v.v0 = v0; v.v1 = v1; v.d0 = d0; v.d1 = d1;
    return v;
  endfunction

  vec_t vt[17];

  initial begin
    vt[0]  = mk(0, 'h0, 0, 'h0,  0, 0, 0, 0, 'h0,  0, 0, 'h0, 'h0);
    vt[1]  = mk(1, 'h8, 0, 'h0,  1, 0, 0, 1, 'h8,  1, 0, 'h3401_1100, 'h0);
    vt[2]  = mk(1, 'h0, 0, 'h0,  1, 0, 0, 1, 'h0,  1, 0, 'hA000_0000, 'h0);
    vt[3]  = mk(1, 'h4, 0, 'h0,  1, 0, 0, 1, 'h4,  1, 0, 'hA000_0001, 'h0);
    vt[4]  = mk(1, 'h8, 0, 'h0,  1, 0, 0, 1, 'h8,  1, 0, 'h3401_1100, 'h0);
    vt[5]  = mk(1, 'hC, 0, 'h0,  1, 0, 0, 1, 'hC,  1, 0, 'hA000_0003, 'h0);
    vt[6]  = mk(0, 'h0, 0, 'h0,  0, 0, 0, 0, 'h0,  0, 0, 'hA000_0003, 'h0);
    vt[7]  = mk(0, 'h0, 1, 'h10, 0, 1, 0, 1, 'h10, 0, 1, 'hA000_0003, 'hA000_0004);
    vt[8]  = mk(1, 'h0, 1, 'h4,  1, 0, 0, 1, 'h0,  1, 0, 'hA000_0000, 'hA000_0004);
    vt[9]  = mk(1, 'h4, 1, 'h4,  1, 0, 0, 1, 'h4,  1, 0, 'hA000_0001, 'hA000_0004);
    vt[10] = mk(1, 'h8, 1, 'h4,  1, 0, 0, 1, 'h8,  1, 0, 'h3401_1100, 'hA000_0004);
    vt[11] = mk(1, 'hC, 1, 'h4,  1, 0, 0, 1, 'hC,  1, 0, 'hA000_0003, 'hA000_0004);
    vt[12] = mk(1, 'hC, 1, 'h4,  0, 1, 1, 1, 'h4,  0, 1, 'hA000_0003, 'hA000_0001);
    vt[13] = mk(1, 'hC, 1, 'h8,  1, 0, 0, 1, 'hC,  1, 0, 'hA000_0003, 'hA000_0001);
    vt[14] = mk(1, 'h0, 0, 'h0,  1, 0, 0, 1, 'h0,  1, 0, 'hA000_0000, 'hA000_0001);
    vt[15] = mk(1, 'h4, 1, 'h8,  1, 0, 0, 1, 'h4,  1, 0, 'hA000_0001, 'hA000_0001);
    vt[16] = mk(0, 'h0, 0, 'h0,  0, 0, 0, 0, 'h0,  0, 0, 'hA000_0001, 'hA000_0001);

    // reset then idle
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #1;
      chk($sformatf("rst%0d rv0", c), 64'(m0_rvalid), 0);
      chk($sformatf("rst%0d rv1", c), 64'(m1_rvalid), 0);
      chk($sformatf("rst%0d rd0", c), 64'(m0_rdata), 0);
      chk($sformatf("rst%0d rd1", c), 64'(m1_rdata), 0);
      chk($sformatf("rst%0d ce", c), 64'(rom_ce), 0);
      chk($sformatf("rst%0d stall", c), 64'(stall_req), 0);
    end
    @(negedge clk);
    rst_n = 1'b1;

    foreach (vt[i]) begin
      @(negedge clk);
      m0_req = vt[i].r0; m0_addr = vt[i].a0;
      m1_req = vt[i].r1; m1_addr = vt[i].a1;
      #1;
      chk($sformatf("v%0d g0", i), 64'(m0_gnt), 64'(vt[i].g0));
      chk($sformatf("v%0d g1", i), 64'(m1_gnt), 64'(vt[i].g1));
      chk($sformatf("v%0d stall", i), 64'(stall_req), 64'(vt[i].st));
      chk($sformatf("v%0d ce", i), 64'(rom_ce), 64'(vt[i].ce));
      chk($sformatf("v%0d raddr", i), 64'(rom_addr), 64'(vt[i].ra));
      @(posedge clk); #1;
      chk($sformatf("v%0d rv0", i), 64'(m0_rvalid), 64'(vt[i].v0));
      chk($sformatf("v%0d rv1", i), 64'(m1_rvalid), 64'(vt[i].v1));
      chk($sformatf("v%0d rd0", i), 64'(m0_rdata), 64'(vt[i].d0));
      chk($sformatf("v%0d rd1", i), 64'(m1_rdata), 64'(vt[i].d1));
    end

    // continuous contention: 4 port-0 grants then one port-1 grant, repeating
    for (int k = 0; k < 10; k++) begin
      logic e1;
      e1 = (k == 4) || (k == 9);
      @(negedge clk);
      m0_req = 1'b1; m0_addr = 'h0;
      m1_req = 1'b1; m1_addr = 'h8;
      #1;
      chk($sformatf("sv%0d g0", k), 64'(m0_gnt), 64'(!e1));
      chk($sformatf("sv%0d g1", k), 64'(m1_gnt), 64'(e1));
      chk($sformatf("sv%0d stall", k), 64'(stall_req), 64'(e1));
      @(posedge clk); #1;
      chk($sformatf("sv%0d rv1", k), 64'(m1_rvalid), 64'(e1));
      chk($sformatf("sv%0d rd1", k), 64'(m1_rdata),
          (k < 4) ? 64'h A000_0001 : 64'h3401_1100);
    end
    @(negedge clk);
    m0_req = 1'b0; m1_req = 1'b0;
    @(posedge clk); #1;
    chk("idle rv0", 64'(m0_rvalid), 0);

    // misaligned fetch
    @(negedge clk);
    m0_req = 1'b1; m0_addr = 'h6;
    #1;
    chk("mis g0", 64'(m0_gnt), 1);
`ifdef ARB_ALIGN_CHECK_EN
    chk("mis ce", 64'(rom_ce), 0);
    @(posedge clk); #1;
    chk("mis rv0", 64'(m0_rvalid), 1);
    chk("mis err0", 64'(m0_err), 1);
    chk("mis rd0", 64'(m0_rdata), 0);
`else
    chk("mis ce", 64'(rom_ce), 1);
    chk("mis raddr", 64'(rom_addr), 'h6);
    @(posedge clk); #1;
    chk("mis rv0", 64'(m0_rvalid), 1);
    chk("mis rd0", 64'(m0_rdata), 64'h A000_0001);
`endif
    @(negedge clk);
    m0_req = 1'b0;

    // reset in the middle of a port-1 response
    @(negedge clk);
    m1_req = 1'b1; m1_addr = 'h10;
    @(posedge clk); #1;
    chk("mr rv1 pre", 64'(m1_rvalid), 1);
    chk("mr rd1 pre", 64'(m1_rdata), 64'h A000_0004);
    @(negedge clk);
    rst_n = 1'b0;
    m1_req = 1'b0;
    #1;
    chk("mr rv1 drop", 64'(m1_rvalid), 0);
    chk("mr rd1 zero", 64'(m1_rdata), 0);
    chk("mr rd0 zero", 64'(m0_rdata), 0);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 2; c++) begin
      @(posedge clk); #1;
      chk($sformatf("post%0d rv0", c), 64'(m0_rvalid), 0);
      chk($sformatf("post%0d rv1", c), 64'(m1_rvalid), 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
